// File: rtl/enc_pkg.sv
// Shared constants for the quadrature encoder position block: defaults,
// decoder state encodings and the debounce counter sizing helper.
package enc_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 50_000;
  localparam int unsigned POS_MIN_DEF    = 0;
  localparam int unsigned POS_MAX_DEF    = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CW1  = 3'd1;
  localparam logic [2:0] ST_CW2  = 3'd2;
  localparam logic [2:0] ST_CW3  = 3'd3;
  localparam logic [2:0] ST_CC1  = 3'd4;
  localparam logic [2:0] ST_CC2  = 3'd5;
  localparam logic [2:0] ST_CC3  = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  // ERR parks the decoder after an illegal move until the rest code returns
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    CW1  = ST_CW1,
    CW2  = ST_CW2,
    CW3  = ST_CW3,
    CC1  = ST_CC1,
    CC2  = ST_CC2,
    CC3  = ST_CC3,
    ERR  = ST_ERR
  } enc_state_e;

  function automatic int unsigned deb_cnt_w(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned DEB_CNT_W_DEF = deb_cnt_w(DEB_CYCLES_DEF);

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw pin.
import enc_pkg::*;

module enc_debounce #(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CW       = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count samples that disagree with the accepted level; any agreement restarts
  always_comb begin
    deb_d = deb_q;
    cnt_d = {CW{1'b0}};
    if (sync2_q != deb_q) begin
      if (cnt_q >= CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      deb_q   <= RST_VAL;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/quad_encoder_pos.sv
// Quadrature encoder reader: debounced A/B detent decoder driving a saturating
// position with sticky limit flags. Optional homing button: ENC_HOME_EN.
import enc_pkg::*;

module quad_encoder_pos #(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned POS_MIN    = POS_MIN_DEF,
  parameter int unsigned POS_MAX    = POS_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_sw,
  output logic [3:0] cont_pos,
  output logic       limSUP,
  output logic       limINF,
  output logic       step_up,
  output logic       step_dn
);

  localparam logic [3:0] P_MIN = 4'(POS_MIN);
  localparam logic [3:0] P_MAX = 4'(POS_MAX);

  logic       a_s, b_s, home_s;
  logic [1:0] ab_s;
  enc_state_e state_q, state_d;
  logic       up_s, dn_s;
  logic [3:0] pos_q, pos_d;
  logic       sup_q, sup_d, inf_q, inf_d;
  logic       step_up_q, step_dn_q;

  // Channels idle high at a detent, so their filters reset to 1
  enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .raw_i(enc_a), .deb_o(a_s)
  );
  enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .raw_i(enc_b), .deb_o(b_s)
  );

`ifdef ENC_HOME_EN
  logic sw_s, sw_prev_q;

  enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_sw (
    .clk(clk), .rst_n(rst_n), .raw_i(enc_sw), .deb_o(sw_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev_q <= 1'b0;
    end else begin
      sw_prev_q <= sw_s;
    end
  end

  assign home_s = sw_s & ~sw_prev_q;
`else
  logic unused_sw_s;
  assign unused_sw_s = enc_sw;
  assign home_s      = 1'b0;
`endif

  assign ab_s = {a_s, b_s};

  // Detent decoder; a double-bit jump lands in ERR unless it is already at rest
  always_comb begin
    state_d = state_q;
    up_s    = 1'b0;
    dn_s    = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab_s)
          2'b01:   state_d = CW1;
          2'b10:   state_d = CC1;
          2'b00:   state_d = ERR;
          default: state_d = IDLE;
        endcase
      end
      CW1: begin
        case (ab_s)
          2'b00:   state_d = CW2;
          2'b11:   state_d = IDLE;
          2'b10:   state_d = ERR;
          default: state_d = CW1;
        endcase
      end
      CW2: begin
        case (ab_s)
          2'b10:   state_d = CW3;
          2'b01:   state_d = CW1;
          2'b11:   state_d = IDLE;
          default: state_d = CW2;
        endcase
      end
      CW3: begin
        case (ab_s)
          2'b11: begin
            state_d = IDLE;
            up_s    = 1'b1;
          end
          2'b00:   state_d = CW2;
          2'b01:   state_d = ERR;
          default: state_d = CW3;
        endcase
      end
      CC1: begin
        case (ab_s)
          2'b00:   state_d = CC2;
          2'b11:   state_d = IDLE;
          2'b01:   state_d = ERR;
          default: state_d = CC1;
        endcase
      end
      CC2: begin
        case (ab_s)
          2'b01:   state_d = CC3;
          2'b10:   state_d = CC1;
          2'b11:   state_d = IDLE;
          default: state_d = CC2;
        endcase
      end
      CC3: begin
        case (ab_s)
          2'b11: begin
            state_d = IDLE;
            dn_s    = 1'b1;
          end
          2'b00:   state_d = CC2;
          2'b10:   state_d = ERR;
          default: state_d = CC3;
        endcase
      end
      ERR: begin
        if (ab_s == 2'b11) begin
          state_d = IDLE;
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating position; a blocked step raises the matching flag instead
  always_comb begin
    pos_d = pos_q;
    sup_d = sup_q;
    inf_d = inf_q;
    if (home_s) begin
      pos_d = P_MIN;
      sup_d = 1'b0;
      inf_d = 1'b0;
    end else if (up_s) begin
      if (pos_q < P_MAX) begin
        pos_d = pos_q + 4'd1;
        inf_d = 1'b0;
      end else begin
        sup_d = 1'b1;
        inf_d = 1'b0;
      end
    end else if (dn_s) begin
      if (pos_q > P_MIN) begin
        pos_d = pos_q - 4'd1;
        sup_d = 1'b0;
      end else begin
        inf_d = 1'b1;
        sup_d = 1'b0;
      end
    end else begin
      pos_d = pos_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q     <= P_MIN;
      sup_q     <= 1'b0;
      inf_q     <= 1'b0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      sup_q     <= sup_d;
      inf_q     <= inf_d;
      step_up_q <= up_s;
      step_dn_q <= dn_s;
    end
  end

  assign cont_pos = pos_q;
  assign limSUP   = sup_q;
  assign limINF   = inf_q;
  assign step_up  = step_up_q;
  assign step_dn  = step_dn_q;

endmodule

// File: tb/tb_quad_encoder_pos.sv
// Scoreboard bench for quad_encoder_pos: detent-level reference model feeds a
// queue of expected step responses; a negedge monitor checks every step pulse.
module tb_quad_encoder_pos;

  localparam int DEB  = 4;
  localparam int HOLD = DEB + 6;
  localparam int LAT  = DEB + 3;
  localparam int PMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_a = 1'b1;
  logic       enc_b = 1'b1;
  logic       enc_sw = 1'b0;
  logic [3:0] cont_pos;
  logic       limSUP, limINF, step_up, step_dn;

  quad_encoder_pos #(.DEB_CYCLES(DEB), .POS_MIN(0), .POS_MAX(PMAX)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .cont_pos(cont_pos), .limSUP(limSUP), .limINF(limINF),
    .step_up(step_up), .step_dn(step_dn)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit up;
    int pos;
    bit sup;
    bit inf;
    int t;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   m_pos = 0;
  bit   m_sup = 1'b0;
  bit   m_inf = 1'b0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every step pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && (step_up || step_dn)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step: got up=%0d dn=%0d pos=%0d expected no step (cycle %0d)",
                 step_up, step_dn, cont_pos, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("step_excl", int'(step_up & step_dn), 0);
        chk("step_dir", int'(step_up), int'(mon_e.up));
        chk("step_pos", int'(cont_pos), mon_e.pos);
        chk("step_limSUP", int'(limSUP), int'(mon_e.sup));
        chk("step_limINF", int'(limINF), int'(mon_e.inf));
        chk("step_latency", cyc - mon_e.t, LAT);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(bit a, bit b);
    enc_a = a;
    enc_b = b;
    tick(HOLD + $urandom_range(0, 3));
  endtask

  task automatic chatter_a();
    int n;
    n = $urandom_range(1, DEB - 1);
    enc_a = ~enc_a;
    tick(n);
    enc_a = ~enc_a;
    tick(HOLD);
  endtask

  // Reference: one whole detent moves the position by one, saturating at the ends
  task automatic model_detent(bit cw);
    if (cw) begin
      if (m_pos < PMAX) begin m_pos++; m_inf = 1'b0; end
      else begin m_sup = 1'b1; m_inf = 1'b0; end
    end else begin
      if (m_pos > 0) begin m_pos--; m_sup = 1'b0; end
      else begin m_inf = 1'b1; m_sup = 1'b0; end
    end
  endtask

  task automatic detent(bit cw, bit chat);
    exp_t e;
    if (cw) set_ab(1'b0, 1'b1); else set_ab(1'b1, 1'b0);
    if (chat) chatter_a();
    set_ab(1'b0, 1'b0);
    if (cw) set_ab(1'b1, 1'b0); else set_ab(1'b0, 1'b1);
    model_detent(cw);
    e.up = cw; e.pos = m_pos; e.sup = m_sup; e.inf = m_inf;
    enc_a = 1'b1;
    enc_b = 1'b1;
    e.t = cyc;
    sbq.push_back(e);
    tick(HOLD + $urandom_range(0, 3));
  endtask

  task automatic check_idle(string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d pending responses expected 0", tag, sbq.size());
      sbq.delete();
    end
    tick(2);
    chk({tag, "_pos"}, int'(cont_pos), m_pos);
    chk({tag, "_limSUP"}, int'(limSUP), int'(m_sup));
    chk({tag, "_limINF"}, int'(limINF), int'(m_inf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    tick(3);
    chk("rst_pos", int'(cont_pos), 0);
    chk("rst_limSUP", int'(limSUP), 0);
    chk("rst_limINF", int'(limINF), 0);
    chk("rst_steps", int'({step_up, step_dn}), 0);
    m_pos = 0; m_sup = 1'b0; m_inf = 1'b0;
    sbq.delete();
    rst_n = 1'b1;
    tick(HOLD);
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    tick(2);
    do_reset();

    repeat (3) detent(1'b1, 1'b0);
    check_idle("cw3");

    while (m_pos < 14) detent(1'b1, 1'b0);
    check_idle("at14");
    repeat (3) detent(1'b1, 1'b0);
    check_idle("sat_up");
    detent(1'b0, 1'b0);
    check_idle("back14");

    do_reset();
    detent(1'b0, 1'b0);
    check_idle("sat_dn");

    set_ab(1'b0, 1'b1);
    repeat (3) chatter_a();
    set_ab(1'b1, 1'b1);
    check_idle("chatter");

    set_ab(1'b0, 1'b1);
    set_ab(1'b0, 1'b0);
    set_ab(1'b0, 1'b1);
    set_ab(1'b1, 1'b1);
    check_idle("partial");
    set_ab(1'b0, 1'b0);
    set_ab(1'b1, 1'b1);
    check_idle("illegal");

    set_ab(1'b0, 1'b1);
    set_ab(1'b0, 1'b0);
    set_ab(1'b1, 1'b0);
    do_reset();
    detent(1'b1, 1'b0);
    check_idle("after_rst");

`ifdef ENC_HOME_EN
    while (m_pos < 9) detent(1'b1, 1'b0);
    check_idle("pre_home");
    enc_sw = 1'b1;
    tick(LAT + 1);
    m_pos = 0; m_sup = 1'b0; m_inf = 1'b0;
    chk("home_pos", int'(cont_pos), m_pos);
    chk("home_limSUP", int'(limSUP), 0);
    enc_sw = 1'b0;
    tick(HOLD);
    check_idle("home");
`endif

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        detent(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 6) begin
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
      end else if (r == 7) begin
        set_ab(1'b0, 1'b0);
        set_ab(1'b1, 1'b1);
      end else if (r == 8) begin
        set_ab(1'b0, 1'b1);
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
      end else begin
        set_ab(1'b1, 1'b0);
        chatter_a();
        set_ab(1'b1, 1'b1);
      end
      if (k % 10 == 9) check_idle("rand");
    end
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
